// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//   Shared constants and types for the systolic array feeder slice.
//   - DEFAULT_ROWS / DEFAULT_COLS / DEFAULT_WIDTH : default array geometry and
//     Q8.8 word width used as parameter defaults by the feeder and interface.
//   - STAT_WIDTH   : width of the optional statistics counters.
//   - feeder_state_t : feeder control states.
//   - drain_cycles() : number of zero-injection cycles needed to flush the
//     skewed wavefront through a ROWS x COLS array.
//   - sat_inc()    : saturating increment for the statistics counters.
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int DEFAULT_ROWS  = 8;
  localparam int DEFAULT_COLS  = 8;
  localparam int DEFAULT_WIDTH = 16;
  localparam int STAT_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  // The last activation entering row ROWS-1 still has to ripple across all
  // COLS processing elements, hence ROWS + COLS - 1 flush cycles.
  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
    return (value == {STAT_WIDTH{1'b1}}) ? value : value + STAT_WIDTH'(1);
  endfunction

endpackage : systolic_pkg

// File: rtl/systolic_array_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_array_feeder_if
//   Activation-vector valid/ready stream into the feeder.
//   Parameters:
//     ROWS  : number of activation rows per vector
//     WIDTH : word width of one activation
//   Signals:
//     act_valid_in  : producer has a vector on act_data_in
//     act_ready_out : feeder will take the vector at the next rising edge
//     act_data_in   : ROWS x WIDTH activation vector
//     act_last_in   : this vector closes the current batch
//   Modports:
//     master : activation producer
//     slave  : feeder
// ---------------------------------------------------------------------------
interface systolic_array_feeder_if
  import systolic_pkg::*;
#(
  parameter int ROWS  = DEFAULT_ROWS,
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                        act_valid_in;
  logic                        act_ready_out;
  logic [ROWS-1:0][WIDTH-1:0]  act_data_in;
  logic                        act_last_in;

  modport master (
    output act_valid_in,
    output act_data_in,
    output act_last_in,
    input  act_ready_out
  );

  modport slave (
    input  act_valid_in,
    input  act_data_in,
    input  act_last_in,
    output act_ready_out
  );

endinterface : systolic_array_feeder_if

// File: rtl/skew_delay_line.sv
// ---------------------------------------------------------------------------
// skew_delay_line
//   Fixed-latency shift register: a word presented on 'data' at a rising edge
//   appears on 'delayed' DEPTH cycles later (visible after the DEPTH-th edge
//   counted from the capturing one). One instance per activation row builds
//   the diagonal skew in front of the systolic array.
//   Parameters:
//     DEPTH : number of register stages (>= 1)
//     WIDTH : word width
//   Ports:
//     clk_in  : clock, rising edge
//     rst_in  : synchronous active-high reset, clears every stage
//     data    : word entering the line
//     delayed : word leaving the line
// ---------------------------------------------------------------------------
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [DEPTH-1:0][WIDTH-1:0] stages;

  // NOTE: this is a register array, not a RAM, so it can and must be reset:
  // stale words left in the line would leak into the array as nonzero bubbles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stages <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's
      // old value; blocking ones would collapse the line into a single stage.
      stages[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign delayed = stages[DEPTH-1];

endmodule : skew_delay_line

// File: rtl/systolic_array_feeder.sv
// ---------------------------------------------------------------------------
// systolic_array_feeder
//   Front end of a weight-stationary systolic array. Latches a weight matrix
//   on request and strobes it into the array, then streams activation vectors
//   with a diagonal skew (row r delayed r+1 cycles) and flushes the array with
//   zero activations after the last vector of a batch.
//
//   Parameters:
//     SYSTOLIC_ARRAY_ROWS : activation rows
//     SYSTOLIC_ARRAY_COLS : PE columns
//     FIXED_POINT_WIDTH   : Q8.8 word width
//
//   Ports:
//     clk_in             : single clock, rising edge
//     rst_in             : synchronous active-high reset
//     weights_load_in    : request to capture weights_data_in (IDLE only)
//     weights_data_in    : ROWS x COLS x WIDTH weight matrix
//     act_if (slave)     : activation stream (valid/ready/data/last)
//     weights_valid_out  : one-cycle weight strobe to the array
//     weights_out        : registered weight matrix, held until next load
//     activations_in_out : ROWS x WIDTH skewed activations to the array
//     busy_out           : high in LOAD, STREAM and DRAIN
//     done_out           : one-cycle pulse on the final DRAIN cycle
//
//   Optional build macro SYSTOLIC_FEEDER_STATS_EN adds:
//     vector_count_out   : accepted vectors since reset / last weight load
//     bubble_count_out   : STREAM cycles without a transfer, same clearing
//   Both counters saturate at all-ones.
// ---------------------------------------------------------------------------
module systolic_array_feeder
  import systolic_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_ROWS = DEFAULT_ROWS,
  parameter int SYSTOLIC_ARRAY_COLS = DEFAULT_COLS,
  parameter int FIXED_POINT_WIDTH   = DEFAULT_WIDTH
) (
  input  logic clk_in,
  input  logic rst_in,

  input  logic weights_load_in,
  input  logic [SYSTOLIC_ARRAY_ROWS-1:0][SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0]
               weights_data_in,

  systolic_array_feeder_if.slave act_if,

  output logic weights_valid_out,
  output logic [SYSTOLIC_ARRAY_ROWS-1:0][SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0]
               weights_out,
  output logic [SYSTOLIC_ARRAY_ROWS-1:0][FIXED_POINT_WIDTH-1:0]
               activations_in_out,
  output logic busy_out,
  output logic done_out
`ifdef SYSTOLIC_FEEDER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] vector_count_out,
  output logic [STAT_WIDTH-1:0] bubble_count_out
`endif
);

  localparam int ROWS         = SYSTOLIC_ARRAY_ROWS;
  localparam int WIDTH        = FIXED_POINT_WIDTH;
  localparam int DRAIN_CYCLES = drain_cycles(SYSTOLIC_ARRAY_ROWS, SYSTOLIC_ARRAY_COLS);
  localparam int CNT_W        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  feeder_state_t state;
  feeder_state_t state_nxt;

  logic             ready;       // combinational act_ready_out
  logic             xfer;        // vector handshake at the coming edge
  logic             load_take;   // weight load accepted at the coming edge
  logic             drain_last;  // final DRAIN cycle
  logic [CNT_W-1:0] drain_cnt;

  logic [ROWS-1:0][WIDTH-1:0] skew_in;

  // -------------------------------------------------------------------------
  // Handshake qualifiers
  // -------------------------------------------------------------------------
  assign xfer       = act_if.act_valid_in && ready;
  assign load_take  = (state == IDLE) && weights_load_in && !rst_in;
  assign drain_last = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

  assign act_if.act_ready_out = ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting state_nxt before the case keeps every path assigned;
    // a branch that forgets it would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE: begin
        // A weight load takes priority; ready is already low in that case.
        if (weights_load_in) begin
          state_nxt = LOAD;
        end else if (xfer) begin
          state_nxt = act_if.act_last_in ? DRAIN : STREAM;
        end
      end
      LOAD: begin
        state_nxt = IDLE;
      end
      STREAM: begin
        if (xfer && act_if.act_last_in) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (all forced low while reset is asserted)
  // -------------------------------------------------------------------------
  always_comb begin
    ready             = 1'b0;
    weights_valid_out = 1'b0;
    busy_out          = 1'b0;
    done_out          = 1'b0;
    if (!rst_in) begin
      case (state)
        IDLE: begin
          ready = !weights_load_in;
        end
        LOAD: begin
          weights_valid_out = 1'b1;
          busy_out          = 1'b1;
        end
        STREAM: begin
          ready    = 1'b1;
          busy_out = 1'b1;
        end
        DRAIN: begin
          busy_out = 1'b1;
          done_out = drain_last;
        end
        default: begin
          ready = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Drain counter: counts cycles spent in DRAIN, parked at zero elsewhere so
  // every batch flushes for the full length.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      drain_cnt <= '0;
    end else if ((state == DRAIN) && !drain_last) begin
      drain_cnt <= drain_cnt + CNT_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Weight register: captured only on an accepted load, held otherwise.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      weights_out <= '0;
    end else if (load_take) begin
      weights_out <= weights_data_in;
    end
  end

  // -------------------------------------------------------------------------
  // Activation skew: every cycle one word per row enters its delay line. A
  // cycle without a transfer (gap, LOAD or DRAIN) feeds zeros, which is what
  // the array treats as a bubble.
  // -------------------------------------------------------------------------
  always_comb begin
    skew_in = '0;
    if (xfer) begin
      skew_in = act_if.act_data_in;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .DEPTH (r + 1),
      .WIDTH (WIDTH)
    ) u_delay (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .data    (skew_in[r]),
      .delayed (activations_in_out[r])
    );
  end

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef SYSTOLIC_FEEDER_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in || load_take) begin
      vector_count_out <= '0;
      bubble_count_out <= '0;
    end else begin
      if (xfer) begin
        vector_count_out <= sat_inc(vector_count_out);
      end
      if ((state == STREAM) && !xfer) begin
        bubble_count_out <= sat_inc(bubble_count_out);
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Structural invariants of the control path
  // -------------------------------------------------------------------------
  a_no_ready_outside_accept: assert property (@(posedge clk_in) disable iff (rst_in)
    ((state == LOAD) || (state == DRAIN)) |-> !act_if.act_ready_out);

  a_done_only_in_drain: assert property (@(posedge clk_in) disable iff (rst_in)
    done_out |-> (state == DRAIN));

endmodule : systolic_array_feeder
